// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU/mux selects, FSM states.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10
   } state_t;

   function automatic logic op_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/cpu_mc_next_state.sv
// Next-state logic for the multi-cycle controller; purely combinational.
module cpu_mc_next_state
   import cpu_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] opcode_q,
   input  logic       mem_rdy,
   output state_t     state_next
);

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:      state_next = FETCH;
         FETCH:     state_next = mem_rdy ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     state_next = EXECUTE;
               OP_LW, OP_SW: state_next = MEM_ADDR;
               OP_BEQ:       state_next = BRANCH;
               OP_J:         state_next = JUMP;
               default:      state_next = FETCH;
            endcase
         end
         // DECODE only admits lw/sw here, so anything not lw is a store
         MEM_ADDR:  state_next = (opcode_q == OP_LW) ? MEM_READ : MEM_WRITE;
         MEM_READ:  state_next = mem_rdy ? MEM_WB : MEM_READ;
         MEM_WB:    state_next = FETCH;
         MEM_WRITE: state_next = mem_rdy ? FETCH : MEM_WRITE;
         EXECUTE:   state_next = ALU_WB;
         ALU_WB:    state_next = FETCH;
         BRANCH:    state_next = FETCH;
         JUMP:      state_next = FETCH;
         default:   state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Moore controller sequencing a multi-cycle MIPS datapath (R-type, lw, sw, beq, j).
//   state     | meaning
//   IDLE      | post-reset, all outputs quiet
//   FETCH     | read instruction at PC, PC+4 -> PC when memory ready
//   DECODE    | branch target -> ALUOut, dispatch on opcode
//   MEM_ADDR  | A + imm -> ALUOut
//   MEM_READ  | load data from memory, wait for ready
//   MEM_WB    | MDR -> rt
//   MEM_WRITE | store B to memory, wait for ready
//   EXECUTE   | A op B
//   ALU_WB    | ALUOut -> rd
//   BRANCH    | compare A/B, PC <- ALUOut if zero
//   JUMP      | PC <- jump target
module cpu_multicycle_control
   import cpu_pkg::*;
#(
   parameter int unsigned STATE_W     = 4,
   parameter int unsigned MEM_WAIT_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               pc_en,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   state_t     state_q;
   state_t     state_next;
   logic [5:0] opcode_q;
   logic       mem_rdy;

   assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   cpu_mc_next_state u_next_state (
      .state      (state_q),
      .opcode     (opcode),
      .opcode_q   (opcode_q),
      .mem_rdy    (mem_rdy),
      .state_next (state_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q <= 6'd0;
      end else if (state_q == DECODE) begin
         opcode_q <= opcode;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_rdy;
            pc_write  = mem_rdy;
         end
         DECODE: begin
            alu_src_b  = SRCB_IMM_SH2;
            illegal_op = ~op_legal(opcode);
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign pc_en = pc_write | (pc_write_cond & zero);
   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Bench for cpu_multicycle_control: vector table, hand-written reset/stall sequences, random instruction stream.
module tb_cpu_multicycle_control;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
      logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       illegal_op;
   } out_t;

   typedef struct {
      state_t st;
      logic   mr;
   } ph_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         fs;
      int         ms;
   } vec_t;

   out_t act;
   assign act = {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                 illegal_op};

   cpu_multicycle_control #(.STATE_W(4), .MEM_WAIT_EN(1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic legal(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b000010;
   endfunction

   // Output table of the controller, one row per state
   function automatic out_t model_out(input state_t st, input logic mr, input logic z,
                                      input logic [5:0] op);
      out_t o;
      o = '0;
      case (st)
         FETCH:     begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
         DECODE:    begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op); end
         MEM_ADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         MEM_READ:  begin o.mem_read = 1; o.i_or_d = 1; end
         MEM_WB:    begin o.reg_write = 1; o.mem_to_reg = 1; end
         MEM_WRITE: begin o.mem_write = 1; o.i_or_d = 1; end
         EXECUTE:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         ALU_WB:    begin o.reg_write = 1; o.reg_dst = 1; end
         BRANCH:    begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
         JUMP:      begin o.pc_write = 1; o.pc_source = 2'b10; end
         default:   ;
      endcase
      o.pc_en = o.pc_write | (o.pc_write_cond & z);
      return o;
   endfunction

   function automatic ph_t mk(input state_t s, input logic m);
      ph_t p;
      p.st = s;
      p.mr = m;
      return p;
   endfunction

   task automatic check_now(input state_t est, input out_t eo, input string tag);
      n_tests++;
      if (state !== 4'(est)) begin
         n_fail++;
         $display("FAIL %s state: got %0d expected %0d", tag, state, est);
      end
      n_tests++;
      if (act !== eo) begin
         n_fail++;
         $display("FAIL %s outputs in %0d: got %h expected %h", tag, est, act, eo);
      end
   endtask

   // One clock cycle: entered at posedge+1, drives inputs, checks mid-cycle, leaves at next posedge+1
   task automatic step(input state_t est, input logic mr, input logic z,
                       input logic [5:0] op, input string tag);
      mem_ready = mr;
      zero      = z;
      opcode    = op;
      #3;
      check_now(est, model_out(est, mr, z, op), tag);
      @(posedge clk);
      #1;
   endtask

   // Expands one instruction into its cycle sequence from the latency rules, then plays it
   task automatic run_instr(input logic [5:0] op, input logic z, input int fs, input int ms,
                            input string tag);
      ph_t q[$];
      logic [5:0] drv_op;
      logic       drv_z;
      for (int i = 0; i < fs; i++) q.push_back(mk(FETCH, 1'b0));
      q.push_back(mk(FETCH, 1'b1));
      q.push_back(mk(DECODE, 1'($urandom)));
      case (op)
         6'b000000: begin
            q.push_back(mk(EXECUTE, 1'($urandom)));
            q.push_back(mk(ALU_WB, 1'($urandom)));
         end
         6'b100011: begin
            q.push_back(mk(MEM_ADDR, 1'($urandom)));
            for (int i = 0; i < ms; i++) q.push_back(mk(MEM_READ, 1'b0));
            q.push_back(mk(MEM_READ, 1'b1));
            q.push_back(mk(MEM_WB, 1'($urandom)));
         end
         6'b101011: begin
            q.push_back(mk(MEM_ADDR, 1'($urandom)));
            for (int i = 0; i < ms; i++) q.push_back(mk(MEM_WRITE, 1'b0));
            q.push_back(mk(MEM_WRITE, 1'b1));
         end
         6'b000100: q.push_back(mk(BRANCH, 1'($urandom)));
         6'b000010: q.push_back(mk(JUMP, 1'($urandom)));
         default: ;
      endcase
      foreach (q[i]) begin
         // opcode only matters up to DECODE; afterwards scramble it to exercise the latch
         drv_op = (q[i].st == FETCH || q[i].st == DECODE) ? op : 6'($urandom);
         drv_z  = (q[i].st == BRANCH) ? z : 1'($urandom);
         step(q[i].st, q[i].mr, drv_z, drv_op, tag);
      end
   endtask

   vec_t vt[10];

   initial begin
      vt[0] = '{op: 6'b000000, z: 1'b0, fs: 0, ms: 0};
      vt[1] = '{op: 6'b100011, z: 1'b0, fs: 0, ms: 2};
      vt[2] = '{op: 6'b000100, z: 1'b1, fs: 0, ms: 0};
      vt[3] = '{op: 6'b000100, z: 1'b0, fs: 0, ms: 0};
      vt[4] = '{op: 6'b000010, z: 1'b0, fs: 0, ms: 0};
      vt[5] = '{op: 6'b001000, z: 1'b0, fs: 0, ms: 0};
      vt[6] = '{op: 6'b101011, z: 1'b0, fs: 0, ms: 0};
      vt[7] = '{op: 6'b101011, z: 1'b1, fs: 1, ms: 3};
      vt[8] = '{op: 6'b100011, z: 1'b1, fs: 2, ms: 0};
      vt[9] = '{op: 6'b111111, z: 1'b1, fs: 1, ms: 0};

      rst       = 1'b1;
      opcode    = 6'd0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      check_now(IDLE, '0, "reset_hold");
      rst = 1'b0;
      step(IDLE, 1'b1, 1'b1, 6'b000000, "reset_release");

      foreach (vt[i]) run_instr(vt[i].op, vt[i].z, vt[i].fs, vt[i].ms, $sformatf("vec%0d", i));

      // sw interrupted by reset while stalled in MEM_WRITE
      step(FETCH, 1'b1, 1'b0, 6'b101011, "sw_rst");
      step(DECODE, 1'b0, 1'b0, 6'b101011, "sw_rst");
      step(MEM_ADDR, 1'b1, 1'b0, 6'b101011, "sw_rst");
      mem_ready = 1'b0;
      #3;
      check_now(MEM_WRITE, model_out(MEM_WRITE, 1'b0, 1'b0, 6'b101011), "sw_rst_wait");
      rst = 1'b1;
      #1;
      check_now(IDLE, '0, "sw_rst_async");
      @(posedge clk);
      #1;
      check_now(IDLE, '0, "sw_rst_held");
      rst = 1'b0;
      step(IDLE, 1'b1, 1'b0, 6'b101011, "sw_rst_release");

      for (int k = 0; k < 60; k++) begin
         logic [5:0] op;
         case ($urandom_range(0, 5))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            default: op = 6'($urandom);
         endcase
         run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $sformatf("rnd%0d", k));
      end
      step(FETCH, 1'b0, 1'b0, 6'b000000, "final_fetch");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Moore-style finite state machine that sequences a multi-cycle MIPS datapath: shared memory for instructions and data, IR, A/B/ALUOut registers and a single ALU.
- Supported instructions: R-type, lw, sw, beq, j.
- Drives all datapath mux selects and register/memory enables each cycle.
- Stalls on a memory-ready handshake.
- Sits between the instruction register's opcode field and the datapath; replaces single-cycle combinational decode for the multi-cycle CPU.

Parameters:
- STATE_W, 4, width of state encoding (must hold 11 states).
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constantly 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled only in DECODE.
- zero  input  1  ALU zero flag; used only in BRANCH.
- mem_ready  input  1  memory completed access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero.
- pc_en  output  1  pc_write | (pc_write_cond & zero).
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back source: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  1 = rd, 0 = rt.
- reg_write  output  1  register-file write.
- alu_src_a  output  1  0 = PC, 1 = A.
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse on unsupported opcode.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Reset: rst=1 forces state=IDLE immediately, regardless of clock, and from any state (including mid-MEM_WRITE). Every output is 0 in IDLE. The cycle after rst deasserts: IDLE -> FETCH.
- Outputs are decoded from state only; pc_en additionally uses zero, and the enables in FETCH additionally use mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH (PC and IR unchanged).
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other -> FETCH, with illegal_op=1 for this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEM_READ, sw -> MEM_WRITE. Opcode is latched into an internal register in DECODE and used here.
- MEM_READ: mem_read=1, i_or_d=1. mem_ready=1 -> MEM_WB; otherwise stay.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. mem_ready=1 -> FETCH; otherwise stay, holding mem_write high.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- Latency with no stalls, including FETCH: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.
- Each wait state adds exactly one cycle per mem_ready=0 cycle.
- Unreachable state encodings -> IDLE on the next clock.
- mem_ready asserted in a state that does not wait on memory is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALUOp constants;
  - alu_src_b and pc_source encodings;
  - state enum: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP.
- Sub-module cpu_mc_next_state: combinational next-state logic (state, latched opcode, mem_ready) -> next state.
- The top module holds the state register, opcode latch and output decode.

Test Plan:
- Reset then R-type (opcode=000000), mem_ready=1 -> states IDLE, FETCH, DECODE, EXECUTE, ALU_WB, FETCH; reg_write=1 and reg_dst=1 only in ALU_WB.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ -> 7 cycles FETCH-to-FETCH; mem_read=1 and i_or_d=1 throughout MEM_READ; reg_write=1, mem_to_reg=1 in MEM_WB.
- beq (000100) with zero=1, then with zero=0 -> pc_en=1, then 0, in the BRANCH cycle; alu_op=01 and pc_source=01 in both cases.
- j (000010) -> pc_write=1, pc_source=10 in the JUMP cycle; FETCH on the 4th cycle.
- Opcode 001000 -> DECODE returns to FETCH, illegal_op pulses exactly 1 cycle; reg_write and mem_write are never asserted.
- sw (101011) with rst asserted mid-MEM_WRITE (mem_ready=0) -> mem_write drops to 0 without waiting for a clock edge; state=IDLE; FETCH one cycle after rst deasserts.
